// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction-fetch front end
package fetch_pkg;

    localparam int IMEM_WORDS_DEFAULT = 101;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

    // Word aligned and inside memory; the shifted compare cannot wrap.
    function automatic logic pc_legal(input logic [31:0] pc, input logic [31:0] words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < words);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry fetch FIFO with flush, head always in slot0
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enq,
    input  logic         deq,
    input  logic         flush,
    input  fetch_entry_t entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic [1:0]   cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= entry;
                        cnt   <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        slot1 <= entry;
                        cnt   <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt != 2'd0) begin
                        slot0 <= slot1;
                        slot1 <= '0;
                        cnt   <= cnt - 2'd1;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= entry;
                    end else if (cnt == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= entry;
                    end else begin
                        slot0 <= entry;
                        cnt   <= 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count = cnt;
    assign head  = (cnt != 2'd0) ? slot0 : '0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, redirect, fault halt and decode handshake
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         fault_next;
    logic [31:0]  fault_pc_next;
    logic         fetch;
    logic         deq;
    logic         legal;
    logic [1:0]   q_count;
    fetch_entry_t q_head;
    fetch_entry_t q_entry;

    assign legal   = pc_legal(pc, WORDS);
    assign deq     = if_valid && if_ready;
    assign q_entry = '{pc: pc, inst: imem_inst};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_RUN;
            pc       <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= 32'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            fault    <= fault_next;
            fault_pc <= fault_pc_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        fault_next    = fault;
        fault_pc_next = fault_pc;
        fetch         = 1'b0;
        if (redirect_valid) begin
            // Redirect wins over everything; a bad target is caught next cycle.
            state_next    = FETCH_RUN;
            pc_next       = redirect_pc;
            fault_next    = 1'b0;
            fault_pc_next = 32'd0;
        end else begin
            case (state)
                FETCH_RUN: begin
                    if (!legal) begin
                        state_next    = FETCH_HALT;
                        fault_next    = 1'b1;
                        fault_pc_next = pc;
                    end else if (q_count != 2'd2 || deq) begin
                        fetch   = 1'b1;
                        pc_next = pc + 32'd4;
                    end
                end
                FETCH_HALT: begin
                end
                default: begin
                    state_next = FETCH_HALT;
                end
            endcase
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .enq   (fetch),
        .deq   (deq),
        .flush (redirect_valid),
        .entry (q_entry),
        .count (q_count),
        .head  (q_head)
    );

    assign imem_addr = pc;
    assign if_valid  = (q_count != 2'd0);
    assign if_pc     = q_head.pc;
    assign if_inst   = q_head.inst;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the single-cycle/pipelined core. Drives the byte address into the combinational instruction memory, captures the returned word, and presents `{pc, inst}` to decode through a valid/ready handshake backed by a 2-entry queue. Handles branch/jump redirects from execute and halts fetching on misaligned or out-of-range PCs.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `IMEM_WORDS`, 101: number of 32-bit words in instruction memory. Valid word indices are 0..IMEM_WORDS-1.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  byte address to instruction memory; memory returns the word at `imem_addr>>2` in the same cycle.
- `imem_inst`  in  32  instruction word from memory (combinational).
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  32  target byte address for the redirect.
- `if_valid`  out  1  queue head holds a valid fetched instruction.
- `if_ready`  in  1  decode accepts the head this cycle.
- `if_pc`  out  32  PC of the head entry.
- `if_inst`  out  32  instruction of the head entry.
- `fault`  out  1  fetch halted on a bad PC.
- `fault_pc`  out  32  PC that caused the fault.

## Operation

- State machine has two states: RUN and HALT.
- `imem_addr` is the registered `pc` in both states.
- Fetch condition, evaluated each cycle: state RUN, `redirect_valid`=0, `pc` legal, and (count<2 or dequeue this cycle).
- On fetch: enqueue `{pc, imem_inst}`, then `pc <= pc+4`. PC arithmetic is mod 2^32, but out-of-range detection always fires before any wrap.
- `pc` is legal when `pc[1:0]==0` and `pc>>2 < IMEM_WORDS`.
- If state is RUN, there is no redirect, and `pc` is illegal:
  - state goes to HALT; `fault` is set to 1 and `fault_pc` to `pc`.
  - Nothing is enqueued and `pc` holds.
- HALT:
  - No fetches.
  - Queued entries still drain to decode normally.
- Dequeue: `if_valid && if_ready`. Head is removed and count decrements.
- Redirect (`redirect_valid`=1) has top priority:
  - Queue is flushed (count=0) and `pc <= redirect_pc`.
  - No fetch occurs that cycle.
  - State goes to RUN; `fault` and `fault_pc` are cleared.
  - A dequeue handshake in the same cycle still counts as a completed transfer; the flush applies afterwards.
  - An illegal `redirect_pc` is detected on the following cycle, then goes RUN→HALT as above.
- Enqueue and dequeue in the same cycle with count=2: allowed. Count stays 2.
- `if_valid` = (count != 0). `if_pc` and `if_inst` show the head entry, or 0 when empty.

## Timing

Reset values:
- `pc` = RESET_PC, so `imem_addr` = RESET_PC.
- count = 0 and state = RUN.
- `if_valid`=0, `if_pc`=0, `if_inst`=0, `fault`=0, `fault_pc`=0.
- Queue storage is zeroed.

Latencies:
- First fetch happens in the first cycle after `rst` deasserts. `if_valid` rises one cycle later.
- Redirect asserted in cycle N:
  - `if_valid`=0 in N+1, with `imem_addr` = target.
  - Target instruction is valid at the head in N+2.
  - Redirect-to-valid latency is 2 cycles.
- With `if_ready` held high, throughput is 1 instruction/cycle with no bubbles.

Boundary cases:
- Backpressure: with `if_ready` low, at most 2 entries are fetched, then `pc` stalls. `pc` always equals the PC of the next unfetched word.
- `rst` asserted mid-operation overrides everything, including redirect, and restores the reset values in the next cycle.

## Structure

- Package `fetch_pkg` contains:
  - `fetch_entry_t` packed struct `{pc[31:0], inst[31:0]}`.
  - `fetch_state_t` enum `{FETCH_RUN, FETCH_HALT}`.
  - `IMEM_WORDS_DEFAULT` constant = 101.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO of `fetch_entry_t`.
  - Ports: `enq`, `deq`, `flush`, `count`, `head`.
  - `flush` takes priority over `enq`.
- `fetch_unit` holds the `pc`, the FSM, the legality check, and the fault registers.

## Test plan

- Reset, then `if_ready`=1 with memory words = index: `if_pc` = 0, 4, 8… on consecutive cycles starting 2 cycles after reset release; `if_inst` = 0, 1, 2…
- Hold `if_ready`=0 for 5 cycles: count saturates at 2 and `imem_addr` stays at 8. On release, PCs 0 and 4 are delivered, then 8, with no duplicates or loss.
- Redirect to 0x40 while the queue is full and `if_ready`=1 in the same cycle: the head transfers, the queue flushes, `if_valid`=0 next cycle, and `if_pc`=0x40 with `if_inst`=mem[16] two cycles after the redirect.
- Sequential fetch reaches PC 0x194 (word 101): `fault`=1, `fault_pc`=0x194, the last queued entries drain, and no further `if_valid` after that.
- Redirect to 0x22 (misaligned): the next cycle gives `fault`=1 and `fault_pc`=0x22. A redirect to 0x10 then clears `fault` and resumes fetch at 0x10.
- Assert `rst` during HALT with a non-empty queue: next cycle all outputs hold their reset values and fetch restarts at RESET_PC.
